// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and baud constants.
// Imported by the transmitter and intended for reuse by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_CLEAN  = 3'd5
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int CLKS_PER_BIT_115200 = 868;

  // Value of the parity bit on the line so the frame has the requested parity.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// System-side byte handshake plus serial line outputs of the UART transmitter.
// Handshake: a byte is accepted on a posedge where Tx_DV & Tx_Ready; Tx_Byte is
// sampled only then, and Tx_DV while Tx_Ready is low is dropped, not queued.
interface uart_tx_if;
  logic       Tx_DV;
  logic [7:0] Tx_Byte;
  logic       Tx_Ready;
  logic       Tx_Serial;
  logic       Tx_Active;
  logic       Tx_Done;

  modport master (
    output Tx_DV, Tx_Byte,
    input  Tx_Ready, Tx_Serial, Tx_Active, Tx_Done
  );

  modport slave (
    input  Tx_DV, Tx_Byte,
    output Tx_Ready, Tx_Serial, Tx_Active, Tx_Done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes
// bit_end_o on the final clock of each bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted request, start + 8 data LSB-first +
// optional parity + 1 or 2 stop bits, all outputs registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int clks_per_bit = CLKS_PER_BIT_115200,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  tx,
  output tx_state_e state_o
);

  if (clks_per_bit < 2) begin : g_bad_cpb
    $fatal(1, "uart_tx: clks_per_bit must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic LAST_STOP = (STOP_BITS == 2);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       parity_q, parity_d;
  logic       serial_q, serial_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       cnt_en, bit_end;

  assign cnt_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                  (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT(clks_per_bit)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!cnt_en),
    .en_i      (cnt_en),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (tx.Tx_DV) begin
          state_d    = ST_START;
          shift_d    = tx.Tx_Byte;
          parity_d   = parity_bit(tx.Tx_Byte, PARITY);
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == LAST_STOP) state_d = ST_CLEAN;
          else                         stop_idx_d = 1'b1;
        end
      end
      ST_CLEAN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes in
  // the same cycle the state does (start bit begins right after acceptance).
  always_comb begin
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      ST_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
      end
      ST_DATA: begin
        serial_d = shift_d[0];
        active_d = 1'b1;
      end
      ST_PARITY: begin
        serial_d = parity_d;
        active_d = 1'b1;
      end
      ST_STOP:  active_d = 1'b1;
      ST_CLEAN: done_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign tx.Tx_Ready  = (state_q == ST_IDLE);
  assign tx.Tx_Serial = serial_q;
  assign tx.Tx_Active = active_q;
  assign tx.Tx_Done   = done_q;
  assign state_o      = state_q;

endmodule
